// File: rtl/uart_csr_arb.sv
// uart_csr_arb
// Round-robin arbiter and sequencer that serialises CSR read/write requests
// from two masters (m0 = host bus bridge, m1 = debug/command port) onto one
// CSR port, then returns registered read data and a one-cycle ack.
//
// Ports
//   clk, rstn        clock and synchronous active-low reset
//   mN_req/we/addr/strb/wdata   request from master N, held until mN_ack
//   mN_ack           one-cycle completion pulse to master N
//   mN_rdata         registered read data, valid in the mN_ack cycle
//   cs/wen/addr/strb/wdata      CSR port, all registered
//   rdata            CSR read data, combinational from addr
//   busy             high whenever the sequencer is not idle
//
// Sequence: IDLE -> ACCESS (cs cycle) -> [WAIT x RD_LAT reads only] -> ACK.
// The CSR addr/strb/wdata registers double as the latched request fields, so
// they hold through WAIT and keep their last value until the next grant.

module uart_csr_arb #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = 4,
   parameter int RD_LAT     = 0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [STRB_WIDTH-1:0] m0_strb,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_ack,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [STRB_WIDTH-1:0] m1_strb,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_ack,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  cs,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [STRB_WIDTH-1:0] strb,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_ACK    = 2'd3
   } state_t;

   localparam logic [1:0] LAT_INIT = 2'(RD_LAT);
   localparam bit         NO_WAIT  = (RD_LAT == 0);

   state_t     state_r;
   logic       last_r;   // id of the most recently acknowledged master
   logic       win_r;    // id of the master owning the current transaction
   logic [1:0] cnt_r;    // remaining read-latency cycles while in WAIT

   logic any_req_s;
   logic gnt_id_s;

   // m1 wins when it is the only requester, or on a tie when m0 went last.
   assign any_req_s = m0_req | m1_req;
   assign gnt_id_s  = m1_req & (~m0_req | ~last_r);

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r  <= ST_IDLE;
         last_r   <= 1'b1;
         win_r    <= 1'b0;
         cnt_r    <= 2'd0;
         cs       <= 1'b0;
         wen      <= 1'b0;
         addr     <= '0;
         strb     <= '0;
         wdata    <= '0;
         busy     <= 1'b0;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  win_r   <= gnt_id_s;
                  cs      <= 1'b1;
                  busy    <= 1'b1;
                  state_r <= ST_ACCESS;
                  if (gnt_id_s) begin
                     wen   <= m1_we;
                     addr  <= m1_addr;
                     strb  <= m1_strb;
                     wdata <= m1_wdata;
                  end else begin
                     wen   <= m0_we;
                     addr  <= m0_addr;
                     strb  <= m0_strb;
                     wdata <= m0_wdata;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               cs  <= 1'b0;
               wen <= 1'b0;
               // wen still carries the latched write flag during this cycle
               if (wen || NO_WAIT) begin
                  if (!wen) begin
                     if (win_r) begin
                        m1_rdata <= rdata;
                     end else begin
                        m0_rdata <= rdata;
                     end
                  end
                  if (win_r) begin
                     m1_ack <= 1'b1;
                  end else begin
                     m0_ack <= 1'b1;
                  end
                  state_r <= ST_ACK;
               end else begin
                  cnt_r   <= LAT_INIT;
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_r == 2'd1) begin
                  if (win_r) begin
                     m1_rdata <= rdata;
                     m1_ack   <= 1'b1;
                  end else begin
                     m0_rdata <= rdata;
                     m0_ack   <= 1'b1;
                  end
                  cnt_r   <= 2'd0;
                  state_r <= ST_ACK;
               end else begin
                  cnt_r <= cnt_r - 2'd1;
               end
            end
            ST_ACK: begin
               m0_ack  <= 1'b0;
               m1_ack  <= 1'b0;
               last_r  <= win_r;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               cs      <= 1'b0;
               wen     <= 1'b0;
               busy    <= 1'b0;
               m0_ack  <= 1'b0;
               m1_ack  <= 1'b0;
               cnt_r   <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_csr_arb.sv
// Directed testbench for uart_csr_arb. Two instances share the request
// inputs: dut_a uses RD_LAT=2, dut_b uses RD_LAT=3. Each has its own CSR
// read model driven from its own addr output. Inputs change and outputs are
// sampled 1 ns after the rising clock edge.

module tb_uart_csr_arb;

   logic        clk;
   logic        rstn;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [15:0] m0_addr, m1_addr;
   logic [3:0]  m0_strb, m1_strb;
   logic [31:0] m0_wdata, m1_wdata;

   logic        cs_a, wen_a, busy_a, m0_ack_a, m1_ack_a;
   logic [15:0] addr_a;
   logic [3:0]  strb_a;
   logic [31:0] wdata_a, rdata_a, m0_rdata_a, m1_rdata_a;

   logic        cs_b, wen_b, busy_b, m0_ack_b, m1_ack_b;
   logic [15:0] addr_b;
   logic [3:0]  strb_b;
   logic [31:0] wdata_b, rdata_b, m0_rdata_b, m1_rdata_b;

   int n_checks = 0;
   int n_pass   = 0;

   // CSR register file model: address 0 holds 0x603, others echo the address.
   function automatic logic [31:0] csr_model(input logic [15:0] a);
      if (a == 16'h0000) return 32'h0000_0603;
      else return {16'hC0DE, a};
   endfunction

   assign rdata_a = csr_model(addr_a);
   assign rdata_b = csr_model(addr_b);

   uart_csr_arb #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .STRB_WIDTH(4), .RD_LAT(2)) dut_a (
      .clk(clk), .rstn(rstn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_strb(m0_strb),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack_a), .m0_rdata(m0_rdata_a),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_strb(m1_strb),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack_a), .m1_rdata(m1_rdata_a),
      .cs(cs_a), .wen(wen_a), .addr(addr_a), .strb(strb_a), .wdata(wdata_a),
      .rdata(rdata_a), .busy(busy_a)
   );

   uart_csr_arb #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .STRB_WIDTH(4), .RD_LAT(3)) dut_b (
      .clk(clk), .rstn(rstn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_strb(m0_strb),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack_b), .m0_rdata(m0_rdata_b),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_strb(m1_strb),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack_b), .m1_rdata(m1_rdata_b),
      .cs(cs_b), .wen(wen_b), .addr(addr_b), .strb(strb_b), .wdata(wdata_b),
      .rdata(rdata_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int cs_in_reset = 0;
      rstn = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0030; m0_strb = 4'hF; m0_wdata = 32'h0000_0033;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0040; m1_strb = 4'hF; m1_wdata = 32'h0000_0044;
      for (int i = 0; i < 2; i++) begin
         step();
         if (cs_a !== 1'b0 || cs_b !== 1'b0) cs_in_reset++;
      end
      n_checks++;
      if (cs_in_reset !== 0) $display("FAIL reset_no_cs: got %0d cs cycles, expected 0", cs_in_reset);
      else n_pass++;
      n_checks++;
      if ({cs_a, wen_a, busy_a, m0_ack_a, m1_ack_a} !== 5'b00000)
         $display("FAIL reset_ctrl: got cs/wen/busy/ack0/ack1=%b expected 00000",
                  {cs_a, wen_a, busy_a, m0_ack_a, m1_ack_a});
      else n_pass++;
      n_checks++;
      if ({addr_a, strb_a, wdata_a} !== 52'd0)
         $display("FAIL reset_port: got addr=%h strb=%h wdata=%h expected 0", addr_a, strb_a, wdata_a);
      else n_pass++;
      n_checks++;
      if ({m0_rdata_a, m1_rdata_a} !== 64'd0)
         $display("FAIL reset_rdata: got m0=%h m1=%h expected 0", m0_rdata_a, m1_rdata_a);
      else n_pass++;
      rstn = 1'b1;
      step();
      n_checks++;
      if (cs_a !== 1'b1 || addr_a !== 16'h0030)
         $display("FAIL reset_first_grant: got cs=%b addr=%h expected cs=1 addr=0030", cs_a, addr_a);
      else n_pass++;
      step();
      n_checks++;
      if (m0_ack_a !== 1'b1 || m1_ack_a !== 1'b0)
         $display("FAIL reset_first_ack: got ack0=%b ack1=%b expected 1 0", m0_ack_a, m1_ack_a);
      else n_pass++;
      m0_req = 1'b0; m1_req = 1'b0;
      step();
      step();
   endtask

   task automatic test_single_write();
      int cs_cnt = 0;
      int ack_step = -1;
      int m1_acks = 0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0004; m0_strb = 4'b0011; m0_wdata = 32'h0000_0A5F;
      for (int i = 1; i <= 5; i++) begin
         step();
         if (cs_a === 1'b1) begin
            cs_cnt++;
            n_checks++;
            if (wen_a !== 1'b1 || addr_a !== 16'h0004 || strb_a !== 4'b0011 || wdata_a !== 32'h0000_0A5F)
               $display("FAIL wr_port: got wen=%b addr=%h strb=%b wdata=%h expected 1 0004 0011 00000a5f",
                        wen_a, addr_a, strb_a, wdata_a);
            else n_pass++;
         end
         if (m0_ack_a === 1'b1) begin
            if (ack_step < 0) ack_step = i;
            m0_req = 1'b0;
         end
         if (m1_ack_a === 1'b1) m1_acks++;
      end
      n_checks++;
      if (cs_cnt !== 1) $display("FAIL wr_cs_count: got %0d expected 1", cs_cnt);
      else n_pass++;
      n_checks++;
      if (ack_step !== 2) $display("FAIL wr_ack_latency: got %0d expected 2", ack_step);
      else n_pass++;
      n_checks++;
      if (m0_rdata_a !== 32'd0 || m1_acks !== 0)
         $display("FAIL wr_rdata_kept: got m0_rdata=%h m1_acks=%0d expected 0 0", m0_rdata_a, m1_acks);
      else n_pass++;
   endtask

   task automatic test_read_lat2();
      int cs_cnt = 0;
      int ack_a = -1;
      int ack_b = -1;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0000; m1_strb = 4'h0; m1_wdata = 32'h0;
      for (int i = 1; i <= 7; i++) begin
         step();
         if (cs_a === 1'b1) begin
            cs_cnt++;
            n_checks++;
            if (wen_a !== 1'b0) $display("FAIL rd_wen: got %b expected 0", wen_a);
            else n_pass++;
         end
         if (i >= 1 && i <= 3) begin
            n_checks++;
            if (addr_a !== 16'h0000) $display("FAIL rd_addr_hold: step %0d got %h expected 0000", i, addr_a);
            else n_pass++;
         end
         if (m1_ack_a === 1'b1 && ack_a < 0) begin
            ack_a = i;
            n_checks++;
            if (m1_rdata_a !== 32'h0000_0603) $display("FAIL rd_data_a: got %h expected 00000603", m1_rdata_a);
            else n_pass++;
         end
         if (m1_ack_b === 1'b1 && ack_b < 0) begin
            ack_b = i;
            m1_req = 1'b0;
            n_checks++;
            if (m1_rdata_b !== 32'h0000_0603) $display("FAIL rd_data_b: got %h expected 00000603", m1_rdata_b);
            else n_pass++;
         end
      end
      n_checks++;
      if (cs_cnt !== 1) $display("FAIL rd_cs_count: got %0d expected 1", cs_cnt);
      else n_pass++;
      n_checks++;
      if (ack_a !== 4) $display("FAIL rd_lat2_ack: got step %0d expected 4", ack_a);
      else n_pass++;
      n_checks++;
      if (ack_b !== 5) $display("FAIL rd_lat3_ack: got step %0d expected 5", ack_b);
      else n_pass++;
      n_checks++;
      if (m0_rdata_a !== 32'd0) $display("FAIL rd_other_rdata: got %h expected 0", m0_rdata_a);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      int ncs = 0;
      int nack = 0;
      int both = 0;
      logic [15:0] cs_addr [4];
      logic        ack_who [4];
      logic [15:0] exp_addr [4];
      exp_addr = '{16'h0010, 16'h0020, 16'h0010, 16'h0020};
      for (int k = 0; k < 4; k++) begin
         cs_addr[k] = 16'hFFFF;
         ack_who[k] = 1'bx;
      end
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0010; m0_strb = 4'hF; m0_wdata = 32'h0000_0011;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0020; m1_strb = 4'hF; m1_wdata = 32'h0000_0022;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (cs_a === 1'b1) begin
            if (ncs < 4) cs_addr[ncs] = addr_a;
            ncs++;
         end
         if (m0_ack_a === 1'b1 && m1_ack_a === 1'b1) both++;
         else if (m0_ack_a === 1'b1 || m1_ack_a === 1'b1) begin
            if (nack < 4) ack_who[nack] = m1_ack_a;
            nack++;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      step();
      step();
      n_checks++;
      if (ncs !== 4 || nack !== 4 || both !== 0)
         $display("FAIL sim_counts: got cs=%0d acks=%0d dual=%0d expected 4 4 0", ncs, nack, both);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (cs_addr[k] !== exp_addr[k] || ack_who[k] !== k[0])
            $display("FAIL sim_order: slot %0d got addr=%h ack_m1=%b expected addr=%h ack_m1=%b",
                     k, cs_addr[k], ack_who[k], exp_addr[k], k[0]);
         else n_pass++;
      end
   endtask

   task automatic test_req_drop();
      int cs_cnt = 0;
      int acks_a = 0;
      int acks_b = 0;
      int m0_acks = 0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0008; m1_strb = 4'h0; m1_wdata = 32'h0;
      for (int i = 1; i <= 9; i++) begin
         step();
         if (i == 1) m1_req = 1'b0;
         if (cs_a === 1'b1) cs_cnt++;
         if (m1_ack_a === 1'b1) begin
            acks_a++;
            n_checks++;
            if (i !== 4 || m1_rdata_a !== 32'hC0DE_0008)
               $display("FAIL drop_ack_a: got step %0d data %h expected step 4 data c0de0008", i, m1_rdata_a);
            else n_pass++;
         end
         if (m1_ack_b === 1'b1) acks_b++;
         if (m0_ack_a === 1'b1 || m0_ack_b === 1'b1) m0_acks++;
      end
      n_checks++;
      if (cs_cnt !== 1 || acks_a !== 1 || acks_b !== 1 || m0_acks !== 0)
         $display("FAIL drop_counts: got cs=%0d ack_a=%0d ack_b=%0d m0_acks=%0d expected 1 1 1 0",
                  cs_cnt, acks_a, acks_b, m0_acks);
      else n_pass++;
   endtask

   task automatic test_reset_mid_wait();
      int stray = 0;
      int ack_a = -1;
      int ack_b = -1;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h000C; m0_strb = 4'h0; m0_wdata = 32'h0;
      step();
      step();
      n_checks++;
      if (busy_b !== 1'b1 || cs_b !== 1'b0)
         $display("FAIL mid_wait_state: got busy=%b cs=%b expected 1 0", busy_b, cs_b);
      else n_pass++;
      rstn = 1'b0;
      m0_req = 1'b0;
      step();
      rstn = 1'b1;
      n_checks++;
      if (busy_b !== 1'b0 || m0_ack_b !== 1'b0 || m0_rdata_b !== 32'd0)
         $display("FAIL mid_wait_reset: got busy=%b ack=%b rdata=%h expected 0 0 0", busy_b, m0_ack_b, m0_rdata_b);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         step();
         if (m0_ack_a !== 1'b0 || m0_ack_b !== 1'b0 || cs_a !== 1'b0 || cs_b !== 1'b0) stray++;
      end
      n_checks++;
      if (stray !== 0) $display("FAIL mid_wait_stray: got %0d cycles with ack/cs expected 0", stray);
      else n_pass++;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0000;
      for (int i = 1; i <= 7; i++) begin
         step();
         if (m0_ack_a === 1'b1 && ack_a < 0) ack_a = i;
         if (m0_ack_b === 1'b1 && ack_b < 0) begin
            ack_b = i;
            m0_req = 1'b0;
            n_checks++;
            if (m0_rdata_b !== 32'h0000_0603) $display("FAIL post_reset_data: got %h expected 00000603", m0_rdata_b);
            else n_pass++;
         end
      end
      n_checks++;
      if (ack_a !== 4 || ack_b !== 5)
         $display("FAIL post_reset_latency: got a=%0d b=%0d expected 4 5", ack_a, ack_b);
      else n_pass++;
   endtask

   initial begin
      rstn = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 16'h0; m0_strb = 4'h0; m0_wdata = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0; m1_strb = 4'h0; m1_wdata = 32'h0;
      #2;
      test_reset();
      test_single_write();
      test_read_lat2();
      test_simultaneous();
      test_req_drop();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_csr_arb.md
# uart_csr_arb

Two-requester arbiter and sequencer for the UART CSR memory interface. It accepts register read and write requests from two independent masters: m0 is the host bus bridge and m1 is the debug/command port. It serialises the requests with round-robin fairness and drives the single CSR port (cs/wen/addr/strb/wdata, combinational rdata). It returns read data and a one-cycle acknowledge to the winning master.

## Interface
Parameters:
- ADDR_WIDTH, 16, CSR address width
- DATA_WIDTH, 32, CSR data width
- STRB_WIDTH, 4, byte-strobe width (DATA_WIDTH/8)
- RD_LAT, 0, extra cycles between the cs cycle and the rdata sample; legal range 0..3

Ports. One clock; reset is synchronous and active-low.
- clk  in  1  clock; all logic on the rising edge
- rstn  in  1  synchronous active-low reset
- mN_req  in  1  request; held high with fields stable until mN_ack (N = 0, 1)
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_WIDTH  register address
- mN_strb  in  STRB_WIDTH  write byte strobes
- mN_wdata  in  DATA_WIDTH  write data
- mN_ack  out  1  one-cycle completion pulse
- mN_rdata  out  DATA_WIDTH  read data; registered, valid in the mN_ack cycle
- cs  out  1  CSR chip select
- wen  out  1  CSR write enable
- addr  out  ADDR_WIDTH  CSR address
- strb  out  STRB_WIDTH  CSR strobes
- wdata  out  DATA_WIDTH  CSR write data
- rdata  in  DATA_WIDTH  CSR read data (combinational from addr)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, WAIT, ACK.
- **IDLE**
  - If no req: stay in IDLE.
  - If exactly one req: grant that master.
  - If both req: grant the master not granted last (pointer `last`; reset value selects m1 as last, so m0 wins the first tie).
  - On grant: latch the winner id, we, addr, strb and wdata into internal registers, then go to ACCESS.
- **ACCESS** (exactly 1 cycle)
  - cs=1 and wen=latched we. addr, strb and wdata are driven from the latched registers.
  - Write, or read with RD_LAT=0: sample rdata at the end of the cycle if it is a read, then go to ACK.
  - Read with RD_LAT>0: load counter with RD_LAT, then go to WAIT.
- **WAIT**
  - cs=0 and wen=0; addr is held at the latched value.
  - The counter decrements each cycle. When the counter equals 1, sample rdata at the end of that cycle and go to ACK.
- **ACK** (exactly 1 cycle)
  - Pulse the winner's mN_ack and set `last` to the winner.
  - If the transaction was a read, mN_rdata holds the sampled value. On a write, mN_rdata is unchanged.
  - Go to IDLE.
- mN_rdata of the non-winning master never changes.
- cs and wen are never high outside ACCESS. addr, strb and wdata keep their last driven value outside ACCESS and WAIT.
- Protocol violations:
  - If mN_req drops mid-transaction, the latched transaction still completes and mN_ack still pulses.
  - Changing fields while req is high has no effect until the next grant.
- A req that rises in the ACK cycle is not seen until IDLE. There is no grant in the ACK cycle.

## Timing
- Reset (rstn=0 at a clock edge):
  - State goes to IDLE.
  - cs, wen, busy, m0_ack and m1_ack = 0.
  - addr, strb, wdata, m0_rdata and m1_rdata = 0.
  - `last` = m1; the counter is cleared.
- Reset mid-transaction aborts the transaction with no ack. An ACCESS cycle cut by reset produces no further cs.
- Latency from req seen in IDLE (cycle t):
  - cs at t+1.
  - ack at t+2 for writes and for reads with RD_LAT=0.
  - ack at t+2+RD_LAT for reads in general.
- Back-to-back: minimum 3 cycles per transaction (IDLE, ACCESS, ACK). With continuous requests from both masters, grants strictly alternate.
- Outputs are registered; there is no combinational path from mN_req to cs.

## Test plan
- **Reset values:** assert rstn=0 for 2 cycles with both reqs high → all outputs 0, busy=0, and no cs in the reset cycles. After release, m0 is granted first.
- **Single write:** m0 write addr=0x0004, strb=4'b0011, wdata=0x0000_0A5F.
  - cs=1 and wen=1 for exactly one cycle with those values.
  - m0_ack pulses 2 cycles after req is seen.
  - m0_rdata is unchanged.
- **Read with RD_LAT=2:** m1 read addr=0x0000 while the CSR model returns 0x0000_0603.
  - cs=1 and wen=0 for one cycle; addr is held for 2 more cycles.
  - m1_ack occurs at t+4 with m1_rdata=0x0000_0603.
- **Simultaneous requests:** both masters request continuously for 4 transactions → grant order m0, m1, m0, m1. Each ack reaches only its own master.
- **Req dropped early:** m1 deasserts req in the ACCESS cycle → the transaction completes and m1_ack still pulses once. No second grant occurs to m1.
- **Reset mid-WAIT:** pull rstn low during WAIT (RD_LAT=3) → no ack and state returns to IDLE. A subsequent m0 read completes normally with correct data.
